// File: rtl/exhaust_mode_fsm_pkg.sv
// Shared types and constants for the kitchen-exhaust mode controller.
// State encodings double as the externally visible mode code.
package exhaust_mode_fsm_pkg;

    localparam int MAX_WIDTH         = 8;
    localparam int MAX_SEC           = (1 << MAX_WIDTH) - 1;
    localparam int HURRICANE_SEC_DEF = 60;
    localparam int CLEAN_SEC_DEF     = 180;
    localparam int GUARD_CYCLES      = 2;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_STANDBY = 3'd1,
        ST_LEVEL1  = 3'd2,
        ST_LEVEL2  = 3'd3,
        ST_LEVEL3  = 3'd4,
        ST_CLEAN   = 3'd5
    } mode_e;

    typedef enum logic [2:0] {
        KEY_NONE  = 3'd0,
        KEY_POWER = 3'd1,
        KEY_CLEAN = 3'd2,
        KEY_L3    = 3'd3,
        KEY_L2    = 3'd4,
        KEY_L1    = 3'd5
    } key_e;

    function automatic logic [1:0] fan_of(input mode_e m);
        logic [1:0] f;
        case (m)
            ST_LEVEL1: f = 2'd1;
            ST_LEVEL2: f = 2'd2;
            ST_LEVEL3: f = 2'd3;
            default:   f = 2'd0;
        endcase
        return f;
    endfunction

    function automatic logic is_timed(input mode_e m);
        return (m == ST_LEVEL3) || (m == ST_CLEAN);
    endfunction

endpackage

// File: rtl/exhaust_mode_fsm_key_arbiter.sv
// Combinational priority select of the debounced key pulses:
// power > clean > l3 > l2 > l1, so at most one key acts per cycle.
module exhaust_mode_fsm_key_arbiter
    import exhaust_mode_fsm_pkg::*;
(
    input  logic key_power,
    input  logic key_l1,
    input  logic key_l2,
    input  logic key_l3,
    input  logic key_clean,
    output key_e key_sel
);

    // Highest-priority pending key wins
    always_comb begin
        key_sel = KEY_NONE;
        if (key_power) begin
            key_sel = KEY_POWER;
        end else if (key_clean) begin
            key_sel = KEY_CLEAN;
        end else if (key_l3) begin
            key_sel = KEY_L3;
        end else if (key_l2) begin
            key_sel = KEY_L2;
        end else if (key_l1) begin
            key_sel = KEY_L1;
        end else begin
            key_sel = KEY_NONE;
        end
    end

endmodule

// File: rtl/exhaust_mode_fsm.sv
// Exhaust-fan mode controller: key-driven fan levels plus two timed modes
// (hurricane and self-clean) that hand off to an external countdown timer.
module exhaust_mode_fsm
    import exhaust_mode_fsm_pkg::*;
#(
    parameter int HURRICANE_SEC = HURRICANE_SEC_DEF,
    parameter int CLEAN_SEC     = CLEAN_SEC_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 key_power,
    input  logic                 key_l1,
    input  logic                 key_l2,
    input  logic                 key_l3,
    input  logic                 key_clean,
    input  logic                 timer_done,
    input  logic [MAX_WIDTH-1:0] timer_count,
    output logic                 timer_start,
    output logic [MAX_WIDTH-1:0] timer_load,
    output logic                 timer_reset,
    output logic [2:0]           mode,
    output logic [1:0]           fan_level,
    output logic [MAX_WIDTH-1:0] remaining_sec,
    output logic                 hurricane_used
);

    generate
        if ((HURRICANE_SEC < 1) || (HURRICANE_SEC > MAX_SEC)) begin : g_bad_hurricane
            $error("HURRICANE_SEC does not fit in MAX_WIDTH bits");
        end
        if ((CLEAN_SEC < 1) || (CLEAN_SEC > MAX_SEC)) begin : g_bad_clean
            $error("CLEAN_SEC does not fit in MAX_WIDTH bits");
        end
    endgenerate

    localparam logic [MAX_WIDTH-1:0] HURRICANE_LOAD = MAX_WIDTH'(HURRICANE_SEC);
    localparam logic [MAX_WIDTH-1:0] CLEAN_LOAD     = MAX_WIDTH'(CLEAN_SEC);
    localparam logic [1:0]           GUARD_LAST     = 2'(GUARD_CYCLES);

    mode_e                state_r;
    mode_e                state_nxt_s;
    key_e                 key_sel_s;
    logic [1:0]           guard_cnt_r;
    logic                 guard_done_s;
    logic                 expiry_s;
    logic                 keyed_exit_s;
    logic                 entering_timed_s;
    logic                 exit_pend_r;
    logic                 timer_start_r;
    logic                 timer_reset_r;
    logic [MAX_WIDTH-1:0] timer_load_r;
    logic [MAX_WIDTH-1:0] remaining_sec_r;
    logic [1:0]           fan_level_r;
    logic                 hurricane_used_r;

    exhaust_mode_fsm_key_arbiter u_key_arbiter (
        .key_power (key_power),
        .key_l1    (key_l1),
        .key_l2    (key_l2),
        .key_l3    (key_l3),
        .key_clean (key_clean),
        .key_sel   (key_sel_s)
    );

    // The timer still reports its idle done for a cycle or two after start,
    // so done is only trusted once the guard has elapsed.
    assign guard_done_s = (guard_cnt_r == GUARD_LAST);
    assign expiry_s     = is_timed(state_r) && guard_done_s && timer_done;

    // Next-state decode; in LEVEL3 a key takes precedence over expiry
    always_comb begin
        state_nxt_s  = state_r;
        keyed_exit_s = 1'b0;
        case (state_r)
            ST_OFF: begin
                if (key_sel_s == KEY_POWER) begin
                    state_nxt_s = ST_STANDBY;
                end else begin
                    state_nxt_s = ST_OFF;
                end
            end
            ST_STANDBY: begin
                case (key_sel_s)
                    KEY_POWER: state_nxt_s = ST_OFF;
                    KEY_CLEAN: state_nxt_s = ST_CLEAN;
                    KEY_L3:    state_nxt_s = hurricane_used_r ? ST_STANDBY : ST_LEVEL3;
                    KEY_L2:    state_nxt_s = ST_LEVEL2;
                    KEY_L1:    state_nxt_s = ST_LEVEL1;
                    default:   state_nxt_s = ST_STANDBY;
                endcase
            end
            ST_LEVEL1, ST_LEVEL2: begin
                case (key_sel_s)
                    KEY_POWER: state_nxt_s = ST_OFF;
                    KEY_L3:    state_nxt_s = hurricane_used_r ? state_r : ST_LEVEL3;
                    KEY_L2:    state_nxt_s = ST_LEVEL2;
                    KEY_L1:    state_nxt_s = ST_LEVEL1;
                    default:   state_nxt_s = state_r;
                endcase
            end
            ST_LEVEL3: begin
                case (key_sel_s)
                    KEY_POWER: begin
                        state_nxt_s  = ST_OFF;
                        keyed_exit_s = 1'b1;
                    end
                    KEY_L2: begin
                        state_nxt_s  = ST_LEVEL2;
                        keyed_exit_s = 1'b1;
                    end
                    KEY_L1: begin
                        state_nxt_s  = ST_LEVEL1;
                        keyed_exit_s = 1'b1;
                    end
                    default: begin
                        state_nxt_s  = expiry_s ? ST_STANDBY : ST_LEVEL3;
                        keyed_exit_s = 1'b0;
                    end
                endcase
            end
            ST_CLEAN: begin
                if (expiry_s) begin
                    state_nxt_s = ST_STANDBY;
                end else begin
                    state_nxt_s = ST_CLEAN;
                end
            end
            default: begin
                state_nxt_s  = ST_OFF;
                keyed_exit_s = 1'b0;
            end
        endcase
    end

    assign entering_timed_s = (state_nxt_s != state_r) && is_timed(state_nxt_s);

    // Guard counter restarts on every state change and saturates
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            guard_cnt_r <= 2'd0;
        end else if (state_nxt_s != state_r) begin
            guard_cnt_r <= 2'd0;
        end else if (guard_cnt_r != GUARD_LAST) begin
            guard_cnt_r <= guard_cnt_r + 2'd1;
        end else begin
            guard_cnt_r <= guard_cnt_r;
        end
    end

    // State, display and hurricane-lockout registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r          <= ST_OFF;
            fan_level_r      <= 2'd0;
            hurricane_used_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            fan_level_r <= fan_of(state_nxt_s);
            if ((state_nxt_s == ST_LEVEL3) && (state_r != ST_LEVEL3)) begin
                hurricane_used_r <= 1'b1;
            end else if (state_nxt_s == ST_OFF) begin
                hurricane_used_r <= 1'b0;
            end else begin
                hurricane_used_r <= hurricane_used_r;
            end
        end
    end

    // Timer handshake: start in the first timed cycle, abort one cycle after a keyed exit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer_start_r   <= 1'b0;
            timer_load_r    <= '0;
            exit_pend_r     <= 1'b0;
            timer_reset_r   <= 1'b0;
            remaining_sec_r <= '0;
        end else begin
            timer_start_r <= entering_timed_s;
            if (entering_timed_s) begin
                timer_load_r <= (state_nxt_s == ST_LEVEL3) ? HURRICANE_LOAD : CLEAN_LOAD;
            end else begin
                timer_load_r <= '0;
            end
            exit_pend_r   <= keyed_exit_s;
            timer_reset_r <= exit_pend_r;
            if (is_timed(state_r) && guard_done_s) begin
                remaining_sec_r <= timer_count;
            end else begin
                remaining_sec_r <= '0;
            end
        end
    end

    assign mode           = state_r;
    assign fan_level      = fan_level_r;
    assign hurricane_used = hurricane_used_r;
    assign timer_start    = timer_start_r;
    assign timer_load     = timer_load_r;
    assign timer_reset    = timer_reset_r;
    assign remaining_sec  = remaining_sec_r;

endmodule

// File: doc/exhaust_mode_fsm.md
EXHAUST_MODE_FSM -- requirements
Module: exhaust_mode_fsm

Interface
REQ-001 SHALL have parameter HURRICANE_SEC, default 60, hurricane (level 3) run time in seconds.
REQ-002 SHALL have parameter CLEAN_SEC, default 180, self-clean run time in seconds.
REQ-003 clk  input  1  100 MHz system clock; rstn  input  1  reset, asynchronous, active-low.
REQ-004 key_power, key_l1, key_l2, key_l3, key_clean  input  1 each  single-cycle debounced key pulses.
REQ-005 timer_done  input  1  countdown-timer done flag (high when idle or expired).
REQ-006 timer_count  input  `MAX_WIDTH  countdown-timer seconds remaining.
REQ-007 timer_start  output  1  rising-edge start request to the countdown timer.
REQ-008 timer_load  output  `MAX_WIDTH  seconds to load, valid while timer_start is high.
REQ-009 timer_reset  output  1  timer abort; idle low, one-cycle high pulse (the timer acts on its falling edge).
REQ-010 mode  output  3  current state encoding; fan_level  output  2  fan drive 0..3.
REQ-011 remaining_sec  output  `MAX_WIDTH  seconds left in a timed state, else 0; hurricane_used  output  1.

Function
REQ-012 States: OFF, STANDBY, LEVEL1, LEVEL2, LEVEL3, CLEAN; fan_level 0,0,1,2,3,0 respectively.
REQ-013 Simultaneous keys in one cycle: priority power > clean > l3 > l2 > l1; at most one transition per cycle.
REQ-014 OFF: key_power -> STANDBY; all other keys ignored.
REQ-015 STANDBY: key_l1 -> LEVEL1; key_l2 -> LEVEL2; key_l3 -> LEVEL3 only if hurricane_used=0; key_clean -> CLEAN; key_power -> OFF.
REQ-016 LEVEL1/LEVEL2: key_l1/key_l2 switch between them; key_l3 -> LEVEL3 if hurricane_used=0; key_power -> OFF; key_clean ignored.
REQ-017 LEVEL3: key_l1/key_l2 -> that level, with timer_reset pulsed; key_power -> OFF, with timer_reset pulsed; expiry -> STANDBY.
REQ-018 CLEAN: all keys, including key_power, ignored; expiry -> STANDBY.
REQ-019 Entry to LEVEL3 sets hurricane_used; only entry to OFF clears it.
REQ-020 On entry to a timed state, timer_start SHALL be high for exactly the first cycle in that state, with timer_load = HURRICANE_SEC or CLEAN_SEC.
REQ-021 Expiry = timer_done high while in a timed state, after a 2-cycle guard counted from state entry; timer_done during the guard is ignored (the timer's idle done is still high).
REQ-022 A timed state left by a key SHALL emit timer_reset one cycle after exit; timer_start and timer_reset are never high together.
REQ-023 timer_start SHALL return low for at least one cycle between consecutive timed-state entries.
REQ-024 remaining_sec SHALL be registered: timer_count while in LEVEL3/CLEAN past the guard, else 0 (1-cycle latency).
REQ-025 mode and fan_level SHALL be registered and change in the same cycle as the state.
REQ-026 Load values SHALL be truncated-checked: HURRICANE_SEC and CLEAN_SEC SHALL fit `MAX_WIDTH (elaboration-time error otherwise).

Reset
REQ-027 rstn low SHALL force, asynchronously: state OFF, fan_level 0, timer_start 0, timer_reset 0, timer_load 0, remaining_sec 0, hurricane_used 0, guard counter 0.
REQ-028 Release of rstn mid-operation SHALL resume from OFF, with no timer_start issued until a new timed-state entry.

Structure
REQ-029 State encodings, HURRICANE_SEC/CLEAN_SEC defaults, and `MAX_WIDTH SHALL live in header_files/parameters.vh.
REQ-030 One sub-module, key_arbiter (combinational priority select of the five key pulses), is natural; the countdown timer is instantiated beside this block at top level, not inside it.

Verification
REQ-031 Power, then key_l3 -> LEVEL3, fan_level 3, timer_start with load 60; after 60 s -> STANDBY, hurricane_used=1.
REQ-032 In STANDBY with hurricane_used=1, key_l3 -> no state change; key_power twice -> OFF then STANDBY, hurricane_used=0.
REQ-033 key_clean, then key_power during CLEAN -> still CLEAN, remaining_sec counts 180..1; expiry -> STANDBY.
REQ-034 key_l2 in LEVEL3 at 40 s left -> LEVEL2 next cycle, timer_reset one-cycle pulse the cycle after, timer_count 0.
REQ-035 key_l1 and key_power in the same cycle in LEVEL2 -> OFF; timer_done high at LEVEL3 entry -> no expiry within the guard.
REQ-036 rstn asserted mid-CLEAN -> all outputs 0 immediately; release -> OFF, no timer_start.
